// File: rtl/mips_main_control_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, state codes,
// datapath mux select codes, and the decoded control-word layout.
package mips_main_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_word_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_main_control_fsm_if.sv
// Controller <-> datapath bundle: opcode/zero in, selects and enables out.
interface mips_main_control_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, zero,
    output pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );

  modport slave (
    output op, zero,
    input  pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );
endinterface

// File: rtl/mips_ctrl_outputs.sv
// Moore output decode: state -> full control word. Unused codes give all zeros.
module mips_ctrl_outputs
  import mips_main_control_fsm_pkg::*;
(
  input  state_t     i_state,
  output ctrl_word_t o_cw
);

  always_comb begin
    o_cw = '0;
    case (i_state)
      S_FETCH: begin
        o_cw.ir_write  = 1'b1;
        o_cw.pc_write  = 1'b1;
        o_cw.alu_src_b = SRCB_FOUR;
      end
      // Branch target is computed speculatively while the opcode decodes.
      S_DECODE: o_cw.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: o_cw.iord = 1'b1;
      S_MEMWB: begin
        o_cw.reg_write  = 1'b1;
        o_cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_cw.iord      = 1'b1;
        o_cw.mem_write = 1'b1;
      end
      S_EXEC: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_cw.reg_write = 1'b1;
        o_cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_op    = ALUOP_SUB;
        o_cw.pc_src    = PCSRC_ALUOUT;
        o_cw.branch    = 1'b1;
      end
      S_ADDIEX: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: o_cw.reg_write = 1'b1;
      S_JUMP: begin
        o_cw.pc_src   = PCSRC_JUMP;
        o_cw.pc_write = 1'b1;
      end
      default: o_cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multi-cycle MIPS main controller: state register, next-state logic, PC enable
// and reset gating of every write enable.
module mips_main_control_fsm
  import mips_main_control_fsm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  mips_main_control_fsm_if.master ctl
);

  state_t     r_state;
  state_t     w_next;
  ctrl_word_t w_cw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (ctl.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  mips_ctrl_outputs u_outputs (
    .i_state (r_state),
    .o_cw    (w_cw)
  );

  // Write enables are held low for the whole reset pulse, not just the FETCH state.
  always_comb begin
    ctl.pc_en      = ~reset & (w_cw.pc_write | (w_cw.branch & ctl.zero));
    ctl.mem_write  = ~reset & w_cw.mem_write;
    ctl.ir_write   = ~reset & w_cw.ir_write;
    ctl.reg_write  = ~reset & w_cw.reg_write;
    ctl.iord       = w_cw.iord;
    ctl.reg_dst    = w_cw.reg_dst;
    ctl.mem_to_reg = w_cw.mem_to_reg;
    ctl.alu_src_a  = w_cw.alu_src_a;
    ctl.alu_src_b  = w_cw.alu_src_b;
    ctl.alu_op     = w_cw.alu_op;
    ctl.pc_src     = w_cw.pc_src;
    ctl.illegal_op = (r_state == S_DECODE) && !is_legal_op(ctl.op);
    ctl.state      = r_state;
  end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Randomized instruction stream checked every cycle against a per-instruction
// state-sequence model, plus directed reset/branch/illegal literal checks.
module tb_mips_main_control_fsm;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  logic [31:0] obs;
  int          ill_cnt, wr_cnt;
  logic        last_pcen;
  logic [1:0]  last_pcsrc;

  mips_main_control_fsm_if ctl ();

  mips_main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Length of the instruction, FETCH through last state inclusive.
  function automatic int seq_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int state_at(input logic [5:0] o, input int k);
    if (k < 2) return k;
    case (o)
      6'b100011: return (k == 2) ? 2 : (k == 3) ? 3 : 4;
      6'b101011: return (k == 2) ? 2 : 5;
      6'b000000: return (k == 2) ? 6 : 7;
      6'b001000: return (k == 2) ? 9 : 10;
      6'b000100: return 8;
      default:   return 11;
    endcase
  endfunction

  // Expected output vector, field order matches got_vec().
  function automatic logic [31:0] exp_vec(input int st, input logic [5:0] o, input logic z);
    logic pcw, br, iord, mw, irw, rw, rdst, m2r, sa, ill;
    logic [1:0] sb, aop, psrc;
    {pcw, br, iord, mw, irw, rw, rdst, m2r, sa, ill} = '0;
    sb = 0; aop = 0; psrc = 0;
    if (st == 0)  begin irw = 1; pcw = 1; sb = 1; end
    if (st == 1)  begin sb = 3; ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010}); end
    if (st == 2)  begin sa = 1; sb = 2; end
    if (st == 3)  iord = 1;
    if (st == 4)  begin rw = 1; m2r = 1; end
    if (st == 5)  begin iord = 1; mw = 1; end
    if (st == 6)  begin sa = 1; aop = 2; end
    if (st == 7)  begin rw = 1; rdst = 1; end
    if (st == 8)  begin sa = 1; aop = 1; psrc = 1; br = 1; end
    if (st == 9)  begin sa = 1; sb = 2; end
    if (st == 10) rw = 1;
    if (st == 11) begin psrc = 2; pcw = 1; end
    return {13'd0, pcw | (br & z), iord, mw, irw, rw, rdst, m2r, sa, sb, aop, psrc, ill, 4'(st)};
  endfunction

  function automatic logic [31:0] got_vec();
    return {13'd0, ctl.pc_en, ctl.iord, ctl.mem_write, ctl.ir_write, ctl.reg_write,
            ctl.reg_dst, ctl.mem_to_reg, ctl.alu_src_a, ctl.alu_src_b, ctl.alu_op,
            ctl.pc_src, ctl.illegal_op, ctl.state};
  endfunction

  // Runs one instruction starting in FETCH, model-checking every cycle.
  // zmode: 0/1 fixed zero flag, 2 random each cycle.
  task automatic run_instr(input logic [5:0] o, input int zmode);
    int n;
    n = seq_len(o);
    obs = 0; ill_cnt = 0; wr_cnt = 0;
    for (int k = 0; k < n; k++) begin
      ctl.op   = o;
      ctl.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      #1;
      chk($sformatf("model op=%b k=%0d", o, k), got_vec(), exp_vec(state_at(o, k), o, ctl.zero));
      obs        = (obs << 4) | 32'(ctl.state);
      ill_cnt   += int'(ctl.illegal_op);
      wr_cnt    += int'(ctl.reg_write | ctl.mem_write);
      last_pcen  = ctl.pc_en;
      last_pcsrc = ctl.pc_src;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] rop;
    reset = 1'b1;
    ctl.op = 6'b101011;
    ctl.zero = 1'b0;
    #1;
    chk("reset state", 32'(ctl.state), 32'd0);
    chk("reset pc_en", 32'(ctl.pc_en), 32'd0);
    chk("reset ir_write", 32'(ctl.ir_write), 32'd0);
    #11 reset = 1'b0;

    // sw up to MEMWR, then reset mid-instruction.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sw walk state", 32'(ctl.state), 32'(state_at(6'b101011, k)));
      if (k < 3) begin @(posedge clk); #1; end
    end
    chk("memwr mem_write", 32'(ctl.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset state", 32'(ctl.state), 32'd0);
    chk("reset mem_write", 32'(ctl.mem_write), 32'd0);
    chk("reset pc_en mid", 32'(ctl.pc_en), 32'd0);
    @(posedge clk); #1;
    chk("held reset state", 32'(ctl.state), 32'd0);
    chk("held reset ir_write", 32'(ctl.ir_write), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post reset state", 32'(ctl.state), 32'd1);
    reset = 1'b1; #1; reset = 1'b0; #1;

    run_instr(6'b100011, 2); chk("lw seq",   obs, 32'h01234);
    run_instr(6'b101011, 2); chk("sw seq",   obs, 32'h0125);
    run_instr(6'b000000, 2); chk("rtype seq", obs, 32'h0167);
    run_instr(6'b001000, 2); chk("addi seq", obs, 32'h019A);
    run_instr(6'b000100, 1);
    chk("beq seq", obs, 32'h018);
    chk("beq z1 pc_en", 32'(last_pcen), 32'd1);
    chk("beq z1 pc_src", 32'(last_pcsrc), 32'd1);
    run_instr(6'b000100, 0);
    chk("beq z0 pc_en", 32'(last_pcen), 32'd0);
    run_instr(6'b000010, 2);
    chk("j seq", obs, 32'h01B);
    chk("j pc_en", 32'(last_pcen), 32'd1);
    chk("j pc_src", 32'(last_pcsrc), 32'd2);
    run_instr(6'b111111, 2);
    chk("illegal seq", obs, 32'h01);
    chk("illegal pulses", 32'(ill_cnt), 32'd1);
    chk("illegal writes", 32'(wr_cnt), 32'd0);
    #1;
    chk("after illegal state", 32'(ctl.state), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 6))
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000000;
        3: rop = 6'b001000;
        4: rop = 6'b000100;
        5: rop = 6'b000010;
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
